// File: rtl/logic_op_sequencer_pkg.sv
// Shared op-code and FSM state encodings for the logic-op sequencer and its core.
package logic_op_sequencer_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND = 2'b00;
    localparam op_t OP_OR  = 2'b01;
    localparam op_t OP_XOR = 2'b10;
    localparam op_t OP_NOT = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/logic_op_sequencer_core.sv
// Combinational logical unit: AND/OR/XOR on X,Y into the low half; NOT inverts the full-width Z.
module logic_core
    import logic_op_sequencer_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  op_t                  i_op,
    input  logic [DATA_W-1:0]    i_x,
    input  logic [DATA_W-1:0]    i_y,
    input  logic [2*DATA_W-1:0]  i_z,
    output logic [DATA_W-1:0]    o_one,
    output logic [DATA_W-1:0]    o_two
);

    always_comb begin
        o_one = '0;
        o_two = '0;
        case (i_op)
            OP_AND: o_one = i_x & i_y;
            OP_OR:  o_one = i_x | i_y;
            OP_XOR: o_one = i_x ^ i_y;
            OP_NOT: begin
                o_one = ~i_z[DATA_W-1:0];
                o_two = ~i_z[2*DATA_W-1:DATA_W];
            end
            default: begin
                o_one = '0;
                o_two = '0;
            end
        endcase
    end

endmodule

// File: rtl/logic_op_sequencer.sv
// Valid/ready front end for logic_core: capture request, register result, present until taken.
// Keeps a chainable accumulator and a saturating count of delivered responses.
module logic_op_sequencer
    import logic_op_sequencer_pkg::*;
#(
    parameter int                DATA_W   = 4,
    parameter int                CNT_W    = 8,
    parameter logic [DATA_W-1:0] ACC_INIT = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [1:0]           i_req_op,
    input  logic [DATA_W-1:0]    i_req_x,
    input  logic [DATA_W-1:0]    i_req_y,
    input  logic [2*DATA_W-1:0]  i_req_z,
    input  logic                 i_req_use_acc,
    input  logic                 i_req_acc_wr,
    input  logic                 i_acc_clr,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [1:0]           o_rsp_op,
    output logic [DATA_W-1:0]    o_rsp_one,
    output logic [DATA_W-1:0]    o_rsp_two,
    output logic [DATA_W-1:0]    o_acc,
    output logic [CNT_W-1:0]     o_op_count
);

    logic [1:0]          r_state;
    op_t                 r_op;
    logic [DATA_W-1:0]   r_x;
    logic [DATA_W-1:0]   r_y;
    logic [2*DATA_W-1:0] r_z;
    logic                r_acc_wr;
    op_t                 r_rsp_op;
    logic [DATA_W-1:0]   r_rsp_one;
    logic [DATA_W-1:0]   r_rsp_two;
    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;

    logic [DATA_W-1:0]   w_one;
    logic [DATA_W-1:0]   w_two;

    logic_core #(.DATA_W(DATA_W)) u_core (
        .i_op  (r_op),
        .i_x   (r_x),
        .i_y   (r_y),
        .i_z   (r_z),
        .o_one (w_one),
        .o_two (w_two)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_AND;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_acc_wr  <= 1'b0;
            r_rsp_op  <= OP_AND;
            r_rsp_one <= '0;
            r_rsp_two <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_op     <= i_req_op;
                        // Reads the register, so a same-cycle acc_clr still yields the pre-clear value.
                        r_x      <= i_req_use_acc ? r_acc : i_req_x;
                        r_y      <= i_req_y;
                        r_z      <= i_req_z;
                        r_acc_wr <= i_req_acc_wr;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_op  <= r_op;
                    r_rsp_one <= w_one;
                    r_rsp_two <= w_two;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= ACC_INIT;
        end else if (i_acc_clr) begin
            r_acc <= ACC_INIT;
        end else if ((r_state == ST_EXEC) && r_acc_wr) begin
            r_acc <= w_one;
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_op    = r_rsp_op;
    assign o_rsp_one   = r_rsp_one;
    assign o_rsp_two   = r_rsp_two;
    assign o_acc       = r_acc;
    assign o_op_count  = r_cnt;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer: directed table, random ops against a reference model, reset corner.
module tb_logic_op_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_req_valid;
    logic [1:0] i_req_op;
    logic [3:0] i_req_x, i_req_y;
    logic [7:0] i_req_z;
    logic       i_req_use_acc, i_req_acc_wr, i_acc_clr, i_rsp_ready;

    logic       o_req_ready, o_rsp_valid;
    logic [1:0] o_rsp_op;
    logic [3:0] o_rsp_one, o_rsp_two, o_acc;
    logic [7:0] o_op_count;

    logic       o2_req_ready, o2_rsp_valid;
    logic [1:0] o2_rsp_op;
    logic [3:0] o2_rsp_one, o2_rsp_two, o2_acc;
    logic [1:0] o2_op_count;

    always #5 i_clk = ~i_clk;

    logic_op_sequencer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_op(i_req_op), .i_req_x(i_req_x), .i_req_y(i_req_y), .i_req_z(i_req_z),
        .i_req_use_acc(i_req_use_acc), .i_req_acc_wr(i_req_acc_wr), .i_acc_clr(i_acc_clr),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_op(o_rsp_op),
        .o_rsp_one(o_rsp_one), .o_rsp_two(o_rsp_two), .o_acc(o_acc), .o_op_count(o_op_count)
    );

    // Narrow counter instance shares all inputs; only its op_count saturation is checked.
    logic_op_sequencer #(.CNT_W(2)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o2_req_ready),
        .i_req_op(i_req_op), .i_req_x(i_req_x), .i_req_y(i_req_y), .i_req_z(i_req_z),
        .i_req_use_acc(i_req_use_acc), .i_req_acc_wr(i_req_acc_wr), .i_acc_clr(i_acc_clr),
        .o_rsp_valid(o2_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_op(o2_rsp_op),
        .o_rsp_one(o2_rsp_one), .o_rsp_two(o2_rsp_two), .o_acc(o2_acc), .o_op_count(o2_op_count)
    );

    typedef struct {
        logic [1:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] z;
        bit         ua;
        bit         aw;
        int         stall;
        bit         clr_idle;
        bit         clr_exec;
        logic [3:0] e1;
        logic [3:0] e2;
    } vec_t;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [3:0] m_acc    = 4'h0;
    int         m_count  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: bitwise rules for AND/OR/XOR, NOT as 255 - z over the full 8-bit Z.
    function automatic logic [7:0] ref_res(input logic [1:0] op, input logic [3:0] x,
                                           input logic [3:0] y, input logic [7:0] z);
        case (op)
            2'b00:   return {4'h0, x & y};
            2'b01:   return {4'h0, x | y};
            2'b10:   return {4'h0, x ^ y};
            default: return 8'hFF - z;
        endcase
    endfunction

    task automatic check_count();
        chk("op_count", {24'h0, o_op_count}, m_count);
        chk("op_count_sat2", {30'h0, o2_op_count}, (m_count > 3) ? 3 : m_count);
    endtask

    task automatic run_op(input vec_t v);
        i_req_valid   = 1'b1;
        i_req_op      = v.op;
        i_req_x       = v.x;
        i_req_y       = v.y;
        i_req_z       = v.z;
        i_req_use_acc = v.ua;
        i_req_acc_wr  = v.aw;
        i_acc_clr     = v.clr_idle;
        i_rsp_ready   = (v.stall == 0);
        if (v.clr_idle) m_acc = 4'h0;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_acc_clr   = v.clr_exec;
        chk("exec_req_ready", o_req_ready, 0);
        chk("latency_vld_early", o_rsp_valid, 0);
        @(posedge i_clk); #1;
        i_acc_clr = 1'b0;
        if (v.clr_exec) m_acc = 4'h0;
        else if (v.aw)  m_acc = v.e1;
        chk("rsp_valid", o_rsp_valid, 1);
        chk("rsp_one", o_rsp_one, v.e1);
        chk("rsp_two", o_rsp_two, v.e2);
        chk("rsp_op", o_rsp_op, v.op);
        chk("acc", o_acc, m_acc);
        for (int i = 0; i < v.stall; i++) begin
            i_req_valid = 1'b1;
            i_req_op    = 2'b11;
            i_req_z     = 8'h00;
            @(posedge i_clk); #1;
            chk("stall_valid", o_rsp_valid, 1);
            chk("stall_req_ready", o_req_ready, 0);
            chk("stall_one", o_rsp_one, v.e1);
            chk("stall_two", o_rsp_two, v.e2);
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b0;
        m_count++;
        chk("done_valid", o_rsp_valid, 0);
        chk("done_req_ready", o_req_ready, 1);
        check_count();
    endtask

    vec_t tbl [10];
    vec_t v;
    logic [7:0] r;
    logic [3:0] xe;

    initial begin
        //           op     x     y     z      ua aw st ci ce  e1    e2
        tbl[0] = '{2'b00, 4'hC, 4'hA, 8'h00, 0, 0, 0, 0, 0, 4'h8, 4'h0};
        tbl[1] = '{2'b11, 4'h0, 4'h0, 8'h3C, 0, 0, 0, 0, 0, 4'h3, 4'hC};
        tbl[2] = '{2'b10, 4'h5, 4'h3, 8'h00, 0, 1, 0, 0, 0, 4'h6, 4'h0};
        tbl[3] = '{2'b01, 4'h0, 4'h1, 8'h00, 1, 0, 0, 0, 0, 4'h7, 4'h0};
        tbl[4] = '{2'b00, 4'hF, 4'hF, 8'h00, 0, 1, 5, 0, 0, 4'hF, 4'h0};
        tbl[5] = '{2'b01, 4'h3, 4'h4, 8'h00, 0, 1, 0, 0, 1, 4'h7, 4'h0};
        tbl[6] = '{2'b10, 4'h0, 4'hA, 8'h00, 0, 1, 0, 0, 0, 4'hA, 4'h0};
        tbl[7] = '{2'b01, 4'h0, 4'h1, 8'h00, 1, 0, 0, 1, 0, 4'hB, 4'h0};
        tbl[8] = '{2'b00, 4'h0, 4'hF, 8'h00, 1, 0, 0, 0, 0, 4'h0, 4'h0};
        tbl[9] = '{2'b11, 4'h5, 4'h5, 8'h00, 0, 0, 1, 0, 0, 4'hF, 4'hF};

        i_rst_n = 1'b0;
        i_req_valid = 1'b0; i_req_op = 2'b00; i_req_x = 4'h0; i_req_y = 4'h0; i_req_z = 8'h00;
        i_req_use_acc = 1'b0; i_req_acc_wr = 1'b0; i_acc_clr = 1'b0; i_rsp_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_req_ready", o_req_ready, 1);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_one", o_rsp_one, 0);
        chk("rst_acc", o_acc, 0);
        check_count();
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int k = 0; k < 10; k++) run_op(tbl[k]);

        for (int k = 0; k < 40; k++) begin
            v.op = 2'($urandom_range(0, 3));
            v.x = 4'($urandom); v.y = 4'($urandom); v.z = 8'($urandom);
            v.ua = ($urandom_range(0, 1) == 1);
            v.aw = ($urandom_range(0, 1) == 1);
            v.stall = $urandom_range(0, 2);
            v.clr_idle = ($urandom_range(0, 7) == 0);
            v.clr_exec = ($urandom_range(0, 7) == 0);
            xe = v.ua ? m_acc : v.x;
            r = ref_res(v.op, xe, v.y, v.z);
            v.e1 = r[3:0];
            v.e2 = r[7:4];
            run_op(v);
        end

        // Load a non-init accumulator, then reset while the next request sits in EXEC.
        v = '{2'b10, 4'hF, 4'h0, 8'h00, 0, 1, 0, 0, 0, 4'hF, 4'h0};
        run_op(v);
        i_req_valid = 1'b1; i_req_op = 2'b01; i_req_x = 4'h1; i_req_y = 4'h2;
        i_req_use_acc = 1'b0; i_req_acc_wr = 1'b1; i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        chk("pre_reset_in_exec", o_req_ready, 0);
        i_rst_n = 1'b0;
        m_acc = 4'h0;
        m_count = 0;
        @(posedge i_clk); #1;
        chk("midrst_rsp_valid", o_rsp_valid, 0);
        chk("midrst_req_ready", o_req_ready, 1);
        chk("midrst_acc", o_acc, 0);
        chk("midrst_rsp_one", o_rsp_one, 0);
        check_count();
        i_rst_n = 1'b1;
        i_rsp_ready = 1'b0;
        @(posedge i_clk); #1;
        chk("postrst_no_rsp", o_rsp_valid, 0);
        chk("postrst_acc", o_acc, 0);

        v = '{2'b00, 4'hC, 4'hA, 8'h00, 0, 0, 0, 0, 0, 4'h8, 4'h0};
        run_op(v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
